// File: rtl/stepper_video_pkg.sv
// rtl/stepper_video_pkg.sv - shared pixel, colour and bank-state types for the stepper video path
package stepper_video_pkg;

   typedef logic [23:0] pixel_t;

   localparam pixel_t COLOR_BLACK = 24'h000000;
   localparam pixel_t COLOR_TRACE = 24'h00c000;

   typedef enum logic {
      BS_CAPTURING = 1'b0,
      BS_FULL      = 1'b1
   } bank_state_t;

   function automatic logic [31:0] lane_top(input int unsigned origin_y,
                                            input int unsigned pitch,
                                            input int unsigned lane);
      return 32'(origin_y + lane * pitch);
   endfunction

endpackage

// File: rtl/trace_pingpong_buffer.sv
// rtl/trace_pingpong_buffer.sv - coil sampler into two banks; full bank goes on display at vsync rise
module trace_pingpong_buffer
   import stepper_video_pkg::*;
#(
   parameter int unsigned NUM_LANES  = 4,
   parameter int unsigned TRACE_LEN  = 256,
   parameter int unsigned SAMPLE_DIV = 50000,
   parameter int unsigned IDX_W      = $clog2(TRACE_LEN)
) (
   input  logic                 i_clock,
   input  logic                 i_reset,
   input  logic [NUM_LANES-1:0] i_coil,
   input  logic                 i_capture_en,
   input  logic                 i_vsync,
   input  logic [IDX_W-1:0]     i_rd_idx,
   output logic [NUM_LANES-1:0] o_cur,
   output logic [NUM_LANES-1:0] o_prev,
   output logic                 o_bank_swap
);

   localparam int unsigned DIV_W = $clog2(SAMPLE_DIV + 1);

   bank_state_t          r_state;
   logic                 r_disp;
   logic [DIV_W-1:0]     r_div;
   logic [IDX_W-1:0]     r_wr;
   logic                 r_vs_d;
   logic [NUM_LANES-1:0] r_mem [2][TRACE_LEN];

   logic w_vs_rise;
   logic w_tick;
   logic w_cap_bank;

   assign w_vs_rise  = i_vsync & ~r_vs_d;
   assign w_cap_bank = ~r_disp;
   assign w_tick     = i_capture_en && (r_state == BS_CAPTURING) &&
                       (r_div == DIV_W'(SAMPLE_DIV - 1));

   // ready is the FULL state; a write landing on a vsync edge only reaches FULL afterwards
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= BS_CAPTURING;
         r_disp      <= 1'b0;
         r_div       <= '0;
         r_wr        <= '0;
         r_vs_d      <= 1'b0;
         o_bank_swap <= 1'b0;
      end else begin
         r_vs_d      <= i_vsync;
         o_bank_swap <= 1'b0;
         case (r_state)
            BS_CAPTURING: begin
               if (i_capture_en) begin
                  if (w_tick) begin
                     r_div <= '0;
                     r_wr  <= r_wr + 1'b1;
                     if (r_wr == IDX_W'(TRACE_LEN - 1)) r_state <= BS_FULL;
                  end else begin
                     r_div <= r_div + 1'b1;
                  end
               end
            end
            BS_FULL: begin
               if (w_vs_rise) begin
                  r_disp      <= ~r_disp;
                  o_bank_swap <= 1'b1;
                  r_state     <= BS_CAPTURING;
               end
            end
            default: r_state <= BS_CAPTURING;
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (w_tick) r_mem[w_cap_bank][r_wr] <= i_coil;
   end

   assign o_cur  = r_mem[r_disp][i_rd_idx];
   assign o_prev = r_mem[r_disp][i_rd_idx - IDX_W'(1)];

endmodule

// File: rtl/stepper_trace_overlay.sv
// rtl/stepper_trace_overlay.sv - draws sampled coil levels as a 4-lane waveform over the video stream
module stepper_trace_overlay
   import stepper_video_pkg::*;
#(
   parameter int unsigned NUM_LANES   = 4,
   parameter int unsigned TRACE_LEN   = 256,
   parameter int unsigned PIX_SHIFT   = 2,
   parameter int unsigned SAMPLE_DIV  = 50000,
   parameter int unsigned ORIGIN_X    = 100,
   parameter int unsigned ORIGIN_Y    = 300,
   parameter int unsigned LANE_HEIGHT = 40,
   parameter int unsigned LANE_PITCH  = 60,
   parameter pixel_t      TRACE_COLOR = COLOR_TRACE
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NUM_LANES-1:0] coil,
   input  logic                 capture_en,
   input  pixel_t               video_in_data,
   input  logic                 video_in_de,
   input  logic                 video_in_hsync,
   input  logic                 video_in_vsync,
   output pixel_t               video_data,
   output logic                 video_de,
   output logic                 video_hsync,
   output logic                 video_vsync,
   output logic                 bank_swap
);

   localparam int unsigned IDX_W    = $clog2(TRACE_LEN);
   localparam int unsigned X_END    = ORIGIN_X + (TRACE_LEN << PIX_SHIFT);
   localparam int unsigned Y_END    = ORIGIN_Y + (NUM_LANES - 1) * LANE_PITCH + LANE_HEIGHT;
   localparam int unsigned X_W      = $clog2(X_END + 1);
   localparam int unsigned Y_W      = $clog2(Y_END + 1);
   localparam int unsigned OFF_MASK = (1 << PIX_SHIFT) - 1;

   // raster counters saturate at the window end so long lines never wrap back into it
   logic [X_W-1:0] r_x;
   logic [Y_W-1:0] r_y;
   logic           r_de_d;

   pixel_t r1_data;
   logic   r1_de, r1_hs, r1_vs, r1_draw;

   logic                 w_de_fall;
   logic [31:0]          w_x32, w_y32, w_dx;
   logic                 w_in_x, w_col0, w_draw;
   logic [IDX_W-1:0]     w_idx;
   logic [NUM_LANES-1:0] w_cur, w_prev;

   assign w_de_fall = ~video_in_de & r_de_d;
   assign w_x32     = 32'(r_x);
   assign w_y32     = 32'(r_y);
   assign w_in_x    = video_in_de && (w_x32 >= ORIGIN_X) && (w_x32 < X_END);
   assign w_dx      = w_in_x ? (w_x32 - ORIGIN_X) : '0;
   assign w_idx     = IDX_W'(w_dx >> PIX_SHIFT);
   assign w_col0    = (w_dx & OFF_MASK) == 32'd0;

   trace_pingpong_buffer #(
      .NUM_LANES (NUM_LANES),
      .TRACE_LEN (TRACE_LEN),
      .SAMPLE_DIV(SAMPLE_DIV)
   ) u_buf (
      .i_clock     (clock),
      .i_reset     (reset),
      .i_coil      (coil),
      .i_capture_en(capture_en),
      .i_vsync     (video_in_vsync),
      .i_rd_idx    (w_idx),
      .o_cur       (w_cur),
      .o_prev      (w_prev),
      .o_bank_swap (bank_swap)
   );

   always_comb begin
      w_draw = 1'b0;
      for (int unsigned l = 0; l < NUM_LANES; l++) begin
         if (w_in_x && (w_y32 >= lane_top(ORIGIN_Y, LANE_PITCH, l)) &&
             (w_y32 < lane_top(ORIGIN_Y, LANE_PITCH, l) + LANE_HEIGHT)) begin
            if ((w_cur[l] && (w_y32 == lane_top(ORIGIN_Y, LANE_PITCH, l))) ||
                (!w_cur[l] && (w_y32 == lane_top(ORIGIN_Y, LANE_PITCH, l) + LANE_HEIGHT - 1)) ||
                ((w_idx != '0) && w_col0 && (w_cur[l] != w_prev[l])))
               w_draw = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_x         <= '0;
         r_y         <= '0;
         r_de_d      <= 1'b0;
         r1_data     <= COLOR_BLACK;
         r1_de       <= 1'b0;
         r1_hs       <= 1'b0;
         r1_vs       <= 1'b0;
         r1_draw     <= 1'b0;
         video_data  <= COLOR_BLACK;
         video_de    <= 1'b0;
         video_hsync <= 1'b0;
         video_vsync <= 1'b0;
      end else begin
         r_de_d <= video_in_de;
         if (video_in_de) begin
            if (r_x != X_W'(X_END)) r_x <= r_x + 1'b1;
         end else if (w_de_fall) begin
            r_x <= '0;
         end
         if (video_in_vsync)                        r_y <= '0;
         else if (w_de_fall && r_y != Y_W'(Y_END))  r_y <= r_y + 1'b1;

         r1_data     <= video_in_data;
         r1_de       <= video_in_de;
         r1_hs       <= video_in_hsync;
         r1_vs       <= video_in_vsync;
         r1_draw     <= w_draw;
         video_data  <= r1_draw ? TRACE_COLOR : r1_data;
         video_de    <= r1_de;
         video_hsync <= r1_hs;
         video_vsync <= r1_vs;
      end
   end

endmodule

// File: tb/tb_stepper_trace_overlay.sv
// tb/tb_stepper_trace_overlay.sv - randomized frames checked against a pixel-level model of the overlay
module tb_stepper_trace_overlay;
   import stepper_video_pkg::*;

   localparam int NL = 4, TL = 8, PS = 1, SD = 4;
   localparam int OX = 4, OY = 3, LH = 3, LP = 4;
   localparam logic [23:0] COL = 24'h00c000;
   localparam logic [23:0] FIX = 24'h123456;
   localparam int H_ACT = 24, H_TOT = 30, V_BLK = 3, V_ACT = 20;

   logic clock = 1'b0, reset = 1'b0;
   logic [3:0] coil = '0;
   logic capture_en = 1'b0;
   logic [23:0] video_in_data = '0;
   logic video_in_de = 1'b0, video_in_hsync = 1'b0, video_in_vsync = 1'b0;
   logic [23:0] video_data;
   logic video_de, video_hsync, video_vsync, bank_swap;

   stepper_trace_overlay #(
      .NUM_LANES(NL), .TRACE_LEN(TL), .PIX_SHIFT(PS), .SAMPLE_DIV(SD),
      .ORIGIN_X(OX), .ORIGIN_Y(OY), .LANE_HEIGHT(LH), .LANE_PITCH(LP), .TRACE_COLOR(COL)
   ) dut (
      .clock(clock), .reset(reset), .coil(coil), .capture_en(capture_en),
      .video_in_data(video_in_data), .video_in_de(video_in_de),
      .video_in_hsync(video_in_hsync), .video_in_vsync(video_in_vsync),
      .video_data(video_data), .video_de(video_de), .video_hsync(video_hsync),
      .video_vsync(video_vsync), .bank_swap(bank_swap)
   );

   always #5 clock = ~clock;

   // model: the two banks as sample arrays plus a count of enabled clocks since capture began
   logic [3:0] m_bank [2][TL];
   int  m_disp, m_e;
   bit  m_ready, m_known, m_vs_prev;
   logic [23:0] p_d [2];
   logic p_de [2], p_hs [2], p_vs [2];
   bit  p_v [2], p_k [2], p_rec [2];
   int  p_x [2], p_y [2];
   bit  exp_sw, sw_v, rec;
   logic [23:0] obs [V_ACT][H_ACT];
   logic [3:0] cur_coil = 4'h0;
   int n_pass = 0, n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic bit model_draw(input int x, input int y);
      int dx, idx, top, s, p;
      bit d;
      d = 0;
      if (x < OX || x >= OX + (TL << PS)) return 0;
      dx  = x - OX;
      idx = dx / (1 << PS);
      for (int l = 0; l < NL; l++) begin
         top = OY + l * LP;
         if (y >= top && y < top + LH) begin
            s = int'(m_bank[m_disp][idx][l]);
            p = (idx > 0) ? int'(m_bank[m_disp][idx-1][l]) : s;
            if ((s == 1 && y == top) || (s == 0 && y == top + LH - 1) ||
                (idx > 0 && dx % (1 << PS) == 0 && s != p)) d = 1;
         end
      end
      return d;
   endfunction

   function automatic bit in_win(input int x, input int y);
      return x >= OX && x < OX + (TL << PS) && y >= OY && y < OY + (NL - 1) * LP + LH;
   endfunction

   task automatic step(input logic de, input logic hs, input logic vs, input logic [23:0] d,
                       input logic cen, input logic [3:0] cl, input int x, input int y);
      bit vr, sw;
      @(negedge clock);
      if (p_v[1]) begin
         chk("de", 32'(video_de), 32'(p_de[1]));
         chk("hsync", 32'(video_hsync), 32'(p_hs[1]));
         chk("vsync", 32'(video_vsync), 32'(p_vs[1]));
         if (p_k[1]) chk("data", 32'(video_data), 32'(p_d[1]));
         if (p_rec[1] && p_de[1]) obs[p_y[1]][p_x[1]] = video_data;
      end
      if (sw_v) chk("bank_swap", 32'(bank_swap), 32'(exp_sw));
      p_d[1] = p_d[0]; p_de[1] = p_de[0]; p_hs[1] = p_hs[0]; p_vs[1] = p_vs[0];
      p_v[1] = p_v[0]; p_k[1] = p_k[0]; p_rec[1] = p_rec[0]; p_x[1] = p_x[0]; p_y[1] = p_y[0];

      video_in_de = de; video_in_hsync = hs; video_in_vsync = vs; video_in_data = d;
      capture_en = cen; coil = cl;

      p_d[0]   = (de && model_draw(x, y)) ? COL : d;
      p_k[0]   = !(de && in_win(x, y)) || m_known;
      p_de[0]  = de; p_hs[0] = hs; p_vs[0] = vs; p_v[0] = 1;
      p_rec[0] = rec; p_x[0] = x; p_y[0] = y;

      vr = vs && !m_vs_prev;
      m_vs_prev = vs;
      sw = 0;
      if (m_ready && vr) begin
         m_disp = 1 - m_disp; m_ready = 0; m_e = 0; sw = 1; m_known = 1;
      end else if (!m_ready && cen) begin
         m_e++;
         if (m_e % SD == 0) m_bank[1 - m_disp][m_e / SD - 1] = cl;
         if (m_e == TL * SD) m_ready = 1;
      end
      exp_sw = sw; sw_v = 1;
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      chk("reset_data", 32'(video_data), 32'h0);
      chk("reset_de", 32'(video_de), 32'h0);
      chk("reset_hsync", 32'(video_hsync), 32'h0);
      chk("reset_vsync", 32'(video_vsync), 32'h0);
      chk("reset_swap", 32'(bank_swap), 32'h0);
      video_in_de = 0; video_in_hsync = 0; video_in_vsync = 0; video_in_data = '0;
      capture_en = 0; coil = '0;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      m_disp = 0; m_e = 0; m_ready = 0; m_known = 0; m_vs_prev = 0;
      p_v[0] = 0; p_v[1] = 0; sw_v = 0;
   endtask

   task automatic frame(input bit de_en, input bit fixed, input int cen_mode, input int reset_line);
      logic cen;
      for (int line = 0; line < V_BLK + V_ACT; line++) begin
         for (int col = 0; col < H_TOT; col++) begin
            cen = (cen_mode == 0) ? 1'b0 : (cen_mode == 1) ? 1'b1 : ($urandom_range(0, 7) != 0);
            if (cen_mode == 2 && $urandom_range(0, 15) == 0) cur_coil = 4'($urandom);
            step(de_en && line >= V_BLK && col < H_ACT, col == H_ACT + 1 || col == H_ACT + 2,
                 line == 1, fixed ? FIX : 24'($urandom), cen, cur_coil, col, line - V_BLK);
            if (line == reset_line && col == 12) begin
               do_reset();
               return;
            end
         end
      end
   endtask

   task automatic idle(input int n, input bit toggle, input logic cen);
      for (int i = 0; i < n; i++)
         step(0, 0, 0, 24'($urandom), cen, toggle ? ((m_e + 1 > 3 * SD) ? 4'hf : 4'h0) : cur_coil, 0, 0);
   endtask

   task automatic swap_seq(input int ps, input int pl, input int rise1, input int rise2);
      bit obs_sw [64];
      int pulses;
      pulses = 0;
      for (int k = 1; k <= 51; k++) begin
         step(0, 0, k == rise1 || k == rise2, 24'($urandom),
              (k <= rise2) && !(k >= ps && k < ps + pl), 4'b0101, 0, 0);
         obs_sw[k-1] = bank_swap;
         if (k >= 2 && bank_swap) pulses++;
      end
      chk("swap_coincident_skipped", 32'(obs_sw[rise1]), 32'h0);
      chk("swap_next_vsync", 32'(obs_sw[rise2]), 32'h1);
      chk("swap_pulse_count", 32'(pulses), 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      do_reset();
      swap_seq(0, 0, 32, 34);

      rec = 1;
      frame(1, 1, 0, -1);
      rec = 0;
      chk("lane0_top", 32'(obs[3][5]), 32'(COL));
      chk("lane0_bottom_clear", 32'(obs[5][5]), 32'(FIX));
      chk("lane1_bottom", 32'(obs[9][5]), 32'(COL));
      chk("lane1_top_clear", 32'(obs[7][5]), 32'(FIX));
      chk("lane2_top", 32'(obs[11][9]), 32'(COL));
      chk("lane3_bottom", 32'(obs[17][9]), 32'(COL));
      chk("right_of_window", 32'(obs[3][20]), 32'(FIX));
      chk("left_of_window", 32'(obs[3][3]), 32'(FIX));

      idle(40, 1, 1'b1);
      rec = 1;
      frame(1, 1, 0, -1);
      rec = 0;
      chk("edge_row0", 32'(obs[3][10]), 32'(COL));
      chk("edge_row1", 32'(obs[4][10]), 32'(COL));
      chk("edge_row2", 32'(obs[5][10]), 32'(COL));
      chk("edge_offcol_clear", 32'(obs[4][11]), 32'(FIX));
      chk("no_edge_steady", 32'(obs[4][12]), 32'(FIX));
      chk("idx0_no_edge", 32'(obs[4][4]), 32'(FIX));
      chk("idx0_bottom", 32'(obs[5][4]), 32'(COL));

      frame(0, 0, 2, -1);
      repeat (3) frame(1, 0, 2, -1);
      frame(1, 0, 2, 10);
      idle(15, 0, 1'b1);
      do_reset();
      swap_seq(10, 10, 42, 44);
      repeat (2) frame(1, 0, 2, -1);
      idle(3, 0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
